serializer: RTL and testbench

SERIALIZER -- requirements
Module: serializer

---
 rtl/serializer_pkg.sv | 33 +++
 rtl/serializer_hamming_encode.sv | 33 +++
 rtl/serializer.sv | 108 ++++++++++
 tb/tb_serializer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/serializer_pkg.sv
// Shared definitions for the serializer and its companion receiver.
// Holds the FSM state type and the Hamming helper functions. They are
// defined here once so transmitter and receiver agree on the code geometry.
//   hamming_code_bits(dw)    : number of check bits r, the smallest r with 2**r >= dw + r + 1
//   hamming_coded_width(dw)  : dw + check bits
//   hamming_is_check_pos(p)  : 1 when 1-based code position p holds a check bit (a power of two)
package serializer_pkg;

  // ST_IDLE / ST_SEND encoding is visible on the ready_o / busy_o outputs.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  function automatic int hamming_code_bits(input int dw);
    int r;
    r = 0;
    // Scan downwards so the last hit is the smallest r that satisfies the bound.
    for (int k = 30; k >= 1; k--) begin
      if ((1 << k) >= dw + k + 1) r = k;
    end
    return r;
  endfunction

  function automatic int hamming_coded_width(input int dw);
    return dw + hamming_code_bits(dw);
  endfunction

  function automatic bit hamming_is_check_pos(input int pos);
    return (pos & (pos - 1)) == 0;
  endfunction

endpackage

// File: rtl/serializer_hamming_encode.sv
// hamming_encode: combinational Hamming check-bit generator.
// The data bits sit, in ascending order, in the non-power-of-two positions
// 3,5,6,7,9,... of a 1-based code word. Check bit i is the XOR of every data
// bit whose position has bit i set. code_o[i] is check bit i (position 2**i).
// The receiver's pad/decode logic walks this mapping in reverse.
//   data_i : payload word
//   code_o : check bits, LSB = position 1
module hamming_encode
  import serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  localparam int CODE_BITS = hamming_code_bits(DATA_WIDTH),
  localparam int CODED_WIDTH = hamming_coded_width(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [CODE_BITS-1:0]  code_o
);

  always_comb begin
    int di;
    code_o = '0;
    di     = 0;
    for (int pos = 1; pos <= CODED_WIDTH; pos++) begin
      if (!hamming_is_check_pos(pos)) begin
        for (int i = 0; i < CODE_BITS; i++) begin
          if (((pos >> i) & 1) == 1) code_o[i] = code_o[i] ^ data_i[di];
        end
        di++;
      end
    end
  end

endmodule

// File: rtl/serializer.sv
// serializer: loads a payload word (optionally Hamming-coded) and shifts it
// out MSB first, one bit per cycle with enable_i high.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   parallel_in_i  : payload word, captured when load_i && ready_o
//   load_i         : load request (ignored while busy)
//   ready_o        : idle, accepts a load (equals state == ST_IDLE)
//   enable_i       : bit strobe
//   serial_out_o   : current frame bit, 0 when idle
//   start_o        : first bit of the frame is on serial_out_o
//   busy_o         : frame in progress (equals state == ST_SEND)
//   done_o         : one-cycle pulse after the last bit was strobed
// Handshake: a load is taken on a rising edge where load_i and ready_o are
// both high; there is no queueing, so a load seen while busy is dropped.
module serializer
  import serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int HAS_ECC    = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] parallel_in_i,
  input  logic                  load_i,
  output logic                  ready_o,
  input  logic                  enable_i,
  output logic                  serial_out_o,
  output logic                  start_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int CODE_BITS   = hamming_code_bits(DATA_WIDTH);
  localparam int CODED_WIDTH = hamming_coded_width(DATA_WIDTH);
  localparam int FW          = (HAS_ECC != 0) ? CODED_WIDTH : DATA_WIDTH;
  localparam int CNT_W       = $clog2(FW) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FW - 1);

  logic [FW-1:0] frame;

  generate
    if (HAS_ECC != 0) begin : g_ecc
      logic [CODE_BITS-1:0] code;
      hamming_encode #(.DATA_WIDTH(DATA_WIDTH)) u_enc (
        .data_i (parallel_in_i),
        .code_o (code)
      );
      assign frame = {parallel_in_i, code};
    end else begin : g_raw
      assign frame = parallel_in_i;
    end
  endgenerate

  state_e           state_q, state_d;
  logic [FW-1:0]    shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (load_i) begin
          state_d = ST_SEND;
          shreg_d = frame;
          cnt_d   = '0;
        end
      end
      ST_SEND: begin
        if (enable_i) begin
          shreg_d = {shreg_q[FW-2:0], 1'b0};
          if (cnt_q == LAST_BIT) begin
            // Wrap to 0 so the counter never exceeds FW-1.
            state_d = ST_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ready_o      = (state_q == ST_IDLE);
  assign busy_o       = (state_q == ST_SEND);
  assign serial_out_o = busy_o & shreg_q[FW-1];
  assign start_o      = busy_o & (cnt_q == '0);
  assign done_o       = done_q;

endmodule

// File: tb/tb_serializer.sv
// Directed bench for serializer: raw 8-bit instance plus an ECC instance.
// Inputs are driven and outputs checked on the falling edge.
module tb_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic [7:0] p_data = '0;
  logic       p_load = 1'b0;
  logic       p_en   = 1'b0;
  logic       p_ready, p_serial, p_start, p_busy, p_done;

  logic [7:0] e_data = '0;
  logic       e_load = 1'b0;
  logic       e_en   = 1'b0;
  logic       e_ready, e_serial, e_start, e_busy, e_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serializer #(.DATA_WIDTH(8), .HAS_ECC(0)) u_dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .parallel_in_i (p_data),
    .load_i        (p_load),
    .ready_o       (p_ready),
    .enable_i      (p_en),
    .serial_out_o  (p_serial),
    .start_o       (p_start),
    .busy_o        (p_busy),
    .done_o        (p_done)
  );

  serializer #(.DATA_WIDTH(8), .HAS_ECC(1)) u_ecc (
    .clk_i         (clk),
    .rst_i         (rst),
    .parallel_in_i (e_data),
    .load_i        (e_load),
    .ready_o       (e_ready),
    .enable_i      (e_en),
    .serial_out_o  (e_serial),
    .start_o       (e_start),
    .busy_o        (e_busy),
    .done_o        (e_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_serial"}, p_serial, 0);
    check({tag, "_start"},  p_start,  0);
    check({tag, "_busy"},   p_busy,   0);
    check({tag, "_done"},   p_done,   0);
    check({tag, "_ready"},  p_ready,  1);
  endtask

  // Sends v on the raw instance, starting at the current falling edge.
  // gapped: enable low on even cycles, high on odd ones (each bit held 2 cycles).
  // busy_load_at: cycle index at which a second load (~v) is attempted.
  // abort_at: cycle index at which reset is asserted; the task returns after release.
  // Returns on the done_o cycle so a follow-up call gives a back-to-back reload.
  task automatic send_plain(input logic [7:0] v, input bit gapped,
                            input int busy_load_at, input int abort_at);
    int ncyc;
    int bi;
    ncyc   = gapped ? 16 : 8;
    p_load = 1'b1;
    p_data = v;
    p_en   = gapped ? 1'b0 : 1'b1;
    for (int j = 0; j < ncyc; j++) begin
      @(negedge clk);
      p_load = 1'b0;
      bi = gapped ? j / 2 : j;
      if (j == abort_at) begin
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        repeat (3) begin
          @(negedge clk);
          check("abort_no_done", p_done, 0);
        end
        rst = 1'b0;
        return;
      end
      check("bit",   p_serial, v[7-bi]);
      check("start", p_start,  bi == 0);
      check("busy",  p_busy,   1);
      check("ready", p_ready,  0);
      check("done",  p_done,   0);
      if (j == busy_load_at) begin
        p_load = 1'b1;
        p_data = ~v;
      end
      if (gapped) p_en = (j % 2 == 1);
    end
    @(negedge clk);
    p_load = 1'b0;
    check("done_pulse",  p_done,   1);
    check("done_ready",  p_ready,  1);
    check("done_busy",   p_busy,   0);
    check("done_serial", p_serial, 0);
  endtask

  task automatic send_ecc(input logic [7:0] v, input logic [11:0] f);
    e_load = 1'b1;
    e_data = v;
    e_en   = 1'b1;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      e_load = 1'b0;
      check("ecc_bit",   e_serial, f[11-j]);
      check("ecc_start", e_start,  j == 0);
      check("ecc_busy",  e_busy,   1);
    end
    @(negedge clk);
    check("ecc_done",  e_done,  1);
    check("ecc_ready", e_ready, 1);
    e_en = 1'b0;
    @(negedge clk);
    check("ecc_done_once", e_done, 0);
  endtask

  initial begin
    // Reset values while rst is held.
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_ecc_ready", e_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    // Enable in idle does nothing.
    p_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_en_busy",   p_busy,   0);
      check("idle_en_serial", p_serial, 0);
      check("idle_en_start",  p_start,  0);
    end

    // Basic frame 0xA5 with continuous strobe.
    send_plain(8'hA5, 1'b0, -1, -1);
    @(negedge clk);
    check("a5_done_once", p_done, 0);

    // Gapped strobe 0x3C.
    send_plain(8'h3C, 1'b1, -1, -1);
    @(negedge clk);
    check("3c_done_once", p_done, 0);

    // 0xFF with a load of 0x00 attempted at bit 3; that load must be dropped.
    send_plain(8'hFF, 1'b0, 3, -1);
    @(negedge clk);
    check("ff_done_once", p_done, 0);
    check("ff_no_replay", p_busy, 0);

    // Reset at bit 4 of 0xA5, then 0x5A must go out intact.
    send_plain(8'hA5, 1'b0, -1, 4);
    send_plain(8'h5A, 1'b0, -1, -1);
    @(negedge clk);
    check("5a_done_once", p_done, 0);

    // Back-to-back: reload on the done cycle.
    send_plain(8'h81, 1'b0, -1, -1);
    send_plain(8'h7E, 1'b0, -1, -1);
    @(negedge clk);
    check("b2b_done_once", p_done, 0);
    p_en = 1'b0;

    // ECC frames {data, p3 p2 p1 p0}.
    send_ecc(8'hA5, 12'hA53);
    send_ecc(8'h3C, 12'h3C2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
